// File: rtl/rdma_wr_len_enforcer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rdma_wr_len_enforcer                                         |
// | Description : Re-frames the RDMA write data stream to the byte length      |
// |               carried by each write request. Forces tlast and the          |
// |               final-beat tkeep, drops beats beyond the requested length,   |
// |               ends short bursts early and counts each protocol violation.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   aclk, areset       clock, synchronous active-high reset                  |
// |   s_req_*            write request (valid/ready/len in bytes)              |
// |   s_axis_*           input AXI4-Stream write data                          |
// |   m_axis_*           output AXI4-Stream, re-framed to the request length   |
// |   err_short_cnt      bursts whose input tlast came before the last beat    |
// |   err_long_cnt       bursts with input beats beyond the last beat          |
// |   err_zero_cnt       requests carrying len == 0                            |
// +----------------------------------------------------------------------------+
module rdma_wr_len_enforcer #(
  parameter int DATA_BITS = 512,
  parameter int LEN_BITS  = 28,
  parameter int CNT_BITS  = 16
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   s_req_valid,
  output logic                   s_req_ready,
  input  logic [LEN_BITS-1:0]    s_req_len,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [DATA_BITS-1:0]   s_axis_tdata,
  input  logic [DATA_BITS/8-1:0] s_axis_tkeep,
  input  logic                   s_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [DATA_BITS-1:0]   m_axis_tdata,
  output logic [DATA_BITS/8-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic [CNT_BITS-1:0]    err_short_cnt,
  output logic [CNT_BITS-1:0]    err_long_cnt,
  output logic [CNT_BITS-1:0]    err_zero_cnt
);

  localparam int c_keep_bits = DATA_BITS / 8;
  localparam int c_bb_log    = $clog2(c_keep_bits);
  localparam int c_lw        = LEN_BITS + 1;

  localparam logic [c_lw-1:0]     c_beat_round = c_lw'(c_keep_bits - 1);
  localparam logic [c_lw-1:0]     c_lw_one     = c_lw'(1);
  localparam logic [CNT_BITS-1:0] c_cnt_one    = CNT_BITS'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                 state_q;
  logic [c_lw-1:0]        beats_left_q;
  logic [c_keep_bits-1:0] last_keep_q;
  logic [CNT_BITS-1:0]    err_short_q;
  logic [CNT_BITS-1:0]    err_long_q;
  logic [CNT_BITS-1:0]    err_zero_q;

  // Two-entry output skid: entry 0 drives the master port directly.
  logic [1:0]             skid_cnt_q;
  logic [DATA_BITS-1:0]   skid0_data_q, skid1_data_q;
  logic [c_keep_bits-1:0] skid0_keep_q, skid1_keep_q;
  logic                   skid0_last_q, skid1_last_q;

  // Request decode: beat count rounded up, and byte mask of the tail beat.
  logic [c_lw-1:0]        w_len_ext;
  logic [c_lw-1:0]        w_beats;
  logic [c_bb_log-1:0]    w_rem;
  logic [c_keep_bits-1:0] w_last_keep;

  assign w_len_ext   = {1'b0, s_req_len};
  assign w_beats     = (w_len_ext + c_beat_round) >> c_bb_log;
  assign w_rem       = s_req_len[c_bb_log-1:0];
  assign w_last_keep = (w_rem == '0) ? '1 : ~({c_keep_bits{1'b1}} << w_rem);

  // Ready terms depend only on registered state, so valid never waits on ready.
  assign s_req_ready   = !areset && (state_q == ST_IDLE);
  assign s_axis_tready = !areset &&
                         (((state_q == ST_XFER) && (skid_cnt_q != 2'd2)) ||
                          (state_q == ST_DRAIN));

  logic w_req_fire, w_in_fire, w_fwd, w_pop, w_is_final, w_fwd_last;
  logic [c_keep_bits-1:0] w_fwd_keep;

  assign w_req_fire = s_req_valid && s_req_ready;
  assign w_in_fire  = s_axis_tvalid && s_axis_tready;
  assign w_fwd      = w_in_fire && (state_q == ST_XFER);
  assign w_pop      = m_axis_tvalid && m_axis_tready;
  assign w_is_final = (beats_left_q == c_lw_one);

  // The request-derived last beat wins over input tlast; a short burst keeps
  // the input byte mask on its early last beat.
  assign w_fwd_last = w_is_final || s_axis_tlast;
  assign w_fwd_keep = w_is_final   ? last_keep_q  :
                      s_axis_tlast ? s_axis_tkeep : '1;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= ST_IDLE;
      beats_left_q <= '0;
      last_keep_q  <= '0;
      err_short_q  <= '0;
      err_long_q   <= '0;
      err_zero_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_req_fire) begin
            if (s_req_len == '0) begin
              if (err_zero_q != '1) err_zero_q <= err_zero_q + c_cnt_one;
            end else begin
              beats_left_q <= w_beats;
              last_keep_q  <= w_last_keep;
              state_q      <= ST_XFER;
            end
          end
        end
        ST_XFER: begin
          if (w_in_fire) begin
            beats_left_q <= beats_left_q - c_lw_one;
            if (w_is_final) begin
              if (s_axis_tlast) begin
                state_q <= ST_IDLE;
              end else begin
                if (err_long_q != '1) err_long_q <= err_long_q + c_cnt_one;
                state_q <= ST_DRAIN;
              end
            end else if (s_axis_tlast) begin
              if (err_short_q != '1) err_short_q <= err_short_q + c_cnt_one;
              state_q <= ST_IDLE;
            end
          end
        end
        ST_DRAIN: begin
          if (w_in_fire && s_axis_tlast) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      skid_cnt_q   <= 2'd0;
      skid0_data_q <= '0;
      skid0_keep_q <= '0;
      skid0_last_q <= 1'b0;
      skid1_data_q <= '0;
      skid1_keep_q <= '0;
      skid1_last_q <= 1'b0;
    end else begin
      case (skid_cnt_q)
        2'd0: begin
          if (w_fwd) begin
            skid0_data_q <= s_axis_tdata;
            skid0_keep_q <= w_fwd_keep;
            skid0_last_q <= w_fwd_last;
            skid_cnt_q   <= 2'd1;
          end
        end
        2'd1: begin
          if (w_fwd && w_pop) begin
            skid0_data_q <= s_axis_tdata;
            skid0_keep_q <= w_fwd_keep;
            skid0_last_q <= w_fwd_last;
          end else if (w_fwd) begin
            skid1_data_q <= s_axis_tdata;
            skid1_keep_q <= w_fwd_keep;
            skid1_last_q <= w_fwd_last;
            skid_cnt_q   <= 2'd2;
          end else if (w_pop) begin
            skid_cnt_q   <= 2'd0;
          end
        end
        2'd2: begin
          // Input is stalled when full, so only a pop can happen here.
          if (w_pop) begin
            skid0_data_q <= skid1_data_q;
            skid0_keep_q <= skid1_keep_q;
            skid0_last_q <= skid1_last_q;
            skid_cnt_q   <= 2'd1;
          end
        end
        default: skid_cnt_q <= 2'd0;
      endcase
    end
  end

  assign m_axis_tvalid = (skid_cnt_q != 2'd0);
  assign m_axis_tdata  = skid0_data_q;
  assign m_axis_tkeep  = skid0_keep_q;
  assign m_axis_tlast  = skid0_last_q;

  assign err_short_cnt = err_short_q;
  assign err_long_cnt  = err_long_q;
  assign err_zero_cnt  = err_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_rdma_wr_len_enforcer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_rdma_wr_len_enforcer                                      |
// | Description : Self-checking bench for rdma_wr_len_enforcer. Directed       |
// |               vector table, random bursts with output backpressure scored  |
// |               against a burst-level reference model, and reset recovery.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_rdma_wr_len_enforcer;

  localparam int DATA_BITS = 512;
  localparam int LEN_BITS  = 28;
  localparam int CNT_BITS  = 4;
  localparam int KB        = DATA_BITS / 8;
  localparam int CNT_MAX   = (1 << CNT_BITS) - 1;
  localparam int W         = 640;

  localparam logic [KB-1:0] c_ones = '1;

  logic                  aclk;
  logic                  areset;
  logic                  s_req_valid;
  logic                  s_req_ready;
  logic [LEN_BITS-1:0]   s_req_len;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic [DATA_BITS-1:0]  s_axis_tdata;
  logic [KB-1:0]         s_axis_tkeep;
  logic                  s_axis_tlast;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic [DATA_BITS-1:0]  m_axis_tdata;
  logic [KB-1:0]         m_axis_tkeep;
  logic                  m_axis_tlast;
  logic [CNT_BITS-1:0]   err_short_cnt;
  logic [CNT_BITS-1:0]   err_long_cnt;
  logic [CNT_BITS-1:0]   err_zero_cnt;

  rdma_wr_len_enforcer #(
    .DATA_BITS (DATA_BITS),
    .LEN_BITS  (LEN_BITS),
    .CNT_BITS  (CNT_BITS)
  ) u_dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_req_valid   (s_req_valid),
    .s_req_ready   (s_req_ready),
    .s_req_len     (s_req_len),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .err_short_cnt (err_short_cnt),
    .err_long_cnt  (err_long_cnt),
    .err_zero_cnt  (err_zero_cnt)
  );

  typedef struct {
    logic [DATA_BITS-1:0] data;
    logic [KB-1:0]        keep;
    logic                 last;
  } beat_t;

  typedef struct {
    int            len;
    int            nin;
    logic [KB-1:0] in_keep;
    int            exp_out;
    logic [KB-1:0] exp_keep;
    int            d_short;
    int            d_long;
  } vec_t;

  beat_t                exp_q[$];
  beat_t                mon_b;
  logic [DATA_BITS-1:0] bd [16];
  logic [KB-1:0]        bk [16];
  int                   checks = 0;
  int                   passed = 0;
  int                   burst_out = 0;
  logic [KB-1:0]        last_keep_seen;
  logic                 last_tlast_seen;
  int                   mdl_short, mdl_long, mdl_zero;
  bit                   bp_en;
  bit                   hold_v;
  logic [DATA_BITS+KB:0] hold_p;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h required %0h", nm, act, exp);
  endtask

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  // Byte mask of the final beat for a request of len bytes.
  function automatic logic [KB-1:0] tail_keep(input int len);
    int            rem;
    logic [KB-1:0] one;
    rem = len % KB;
    one = KB'(1);
    if (rem == 0) return c_ones;
    return (one << rem) - one;
  endfunction

  // Output-side ready: free-running random when backpressure is enabled.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      m_axis_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: scoreboard compare and hold-stability check.
  always @(negedge aclk) begin
    if (areset) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", W'(m_axis_tvalid), W'(1'b1));
        chk("hold_payload", W'({m_axis_tlast, m_axis_tkeep, m_axis_tdata}), W'(hold_p));
      end
      hold_v = m_axis_tvalid && !m_axis_tready;
      hold_p = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
      if (m_axis_tvalid && m_axis_tready) begin
        burst_out++;
        last_keep_seen  = m_axis_tkeep;
        last_tlast_seen = m_axis_tlast;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_beat: got tdata %0h with no beat required", m_axis_tdata);
        end else begin
          mon_b = exp_q.pop_front();
          chk("out_beat", W'({m_axis_tlast, m_axis_tkeep, m_axis_tdata}),
              W'({mon_b.last, mon_b.keep, mon_b.data}));
        end
      end
    end
  end

  task automatic send_req(input int len);
    bit acc = 1'b0;
    s_req_valid = 1'b1;
    s_req_len   = LEN_BITS'(len);
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge aclk);
      acc = s_req_ready;
      @(posedge aclk);
      #1;
    end
    s_req_valid = 1'b0;
    if (!acc) begin
      checks++;
      $display("FAIL req_timeout: ready 0 required 1 for len %0d", len);
    end
  endtask

  task automatic send_beat(input logic [DATA_BITS-1:0] d, input logic [KB-1:0] k, input logic l);
    bit acc = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge aclk);
      acc = s_axis_tready;
      @(posedge aclk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    if (!acc) begin
      checks++;
      $display("FAIL beat_timeout: tready 0 required 1");
    end
  endtask

  // Builds a burst, records the expected output from the burst-level rules,
  // then drives the request and its input beats.
  task automatic run_burst(input int len, input int nin, input logic [KB-1:0] kfix,
                           input bit rnd, input bit tmode);
    int    n, k;
    beat_t b;
    n = (len + KB - 1) / KB;
    k = (nin < n) ? nin : n;
    for (int i = 0; i < nin; i++) begin
      for (int j = 0; j < DATA_BITS / 32; j++) bd[i][j*32 +: 32] = $urandom();
      bk[i] = rnd ? {$urandom(), $urandom()} : kfix;
    end
    for (int i = 0; i < k; i++) begin
      b.data = bd[i];
      b.last = (i == k - 1);
      b.keep = c_ones;
      if (i == k - 1) b.keep = (nin >= n) ? tail_keep(len) : bk[i];
      exp_q.push_back(b);
    end
    if (nin < n) mdl_short++;
    if (nin > n) mdl_long++;
    send_req(len);
    if (tmode) begin
      @(negedge aclk);
      chk("req_ready_busy", W'(s_req_ready), W'(1'b0));
      @(posedge aclk);
      #1;
    end
    for (int i = 0; i < nin; i++) begin
      if (rnd) repeat ($urandom_range(0, 1)) begin @(posedge aclk); #1; end
      send_beat(bd[i], bk[i], i == nin - 1);
    end
    if (tmode) begin
      @(negedge aclk);
      chk("req_ready_idle", W'(s_req_ready), W'(1'b1));
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int t = 0; t < 3000 && !done; t++) begin
      @(negedge aclk);
      #1;
      if (!m_axis_tvalid && exp_q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      checks++;
      $display("FAIL drain_timeout: %0d beats still required", exp_q.size());
      exp_q.delete();
    end
    @(posedge aclk);
    #1;
  endtask

  initial begin
    vec_t vecs[10];
    int   tab_short, tab_long, total, len, n, nin, r;

    vecs[0] = '{len:256, nin:4,  in_keep:64'h0,  exp_out:4,  exp_keep:c_ones,                  d_short:0, d_long:0};
    vecs[1] = '{len:100, nin:2,  in_keep:64'h0,  exp_out:2,  exp_keep:64'h0000_000F_FFFF_FFFF, d_short:0, d_long:0};
    vecs[2] = '{len:128, nin:4,  in_keep:64'h3,  exp_out:2,  exp_keep:c_ones,                  d_short:0, d_long:1};
    vecs[3] = '{len:256, nin:2,  in_keep:64'hFF, exp_out:2,  exp_keep:64'h0000_0000_0000_00FF, d_short:1, d_long:0};
    vecs[4] = '{len:64,  nin:1,  in_keep:64'h0,  exp_out:1,  exp_keep:c_ones,                  d_short:0, d_long:0};
    vecs[5] = '{len:1,   nin:1,  in_keep:c_ones, exp_out:1,  exp_keep:64'h1,                   d_short:0, d_long:0};
    vecs[6] = '{len:127, nin:2,  in_keep:64'h0,  exp_out:2,  exp_keep:64'h7FFF_FFFF_FFFF_FFFF, d_short:0, d_long:0};
    vecs[7] = '{len:65,  nin:3,  in_keep:64'h0,  exp_out:2,  exp_keep:64'h1,                   d_short:0, d_long:1};
    vecs[8] = '{len:200, nin:1,  in_keep:64'h0F, exp_out:1,  exp_keep:64'h0F,                  d_short:1, d_long:0};
    vecs[9] = '{len:640, nin:10, in_keep:64'h0,  exp_out:10, exp_keep:c_ones,                  d_short:0, d_long:0};

    areset        = 1'b1;
    s_req_valid   = 1'b0;
    s_req_len     = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    bp_en         = 1'b0;
    mdl_short     = 0;
    mdl_long      = 0;
    mdl_zero      = 0;
    tab_short     = 0;
    tab_long      = 0;

    // Reset state
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_req_ready", W'(s_req_ready), W'(1'b0));
    chk("rst_tready", W'(s_axis_tready), W'(1'b0));
    chk("rst_tvalid", W'(m_axis_tvalid), W'(1'b0));
    chk("rst_out_payload", W'({m_axis_tlast, m_axis_tkeep, m_axis_tdata}), W'(0));
    chk("rst_counters", W'({err_short_cnt, err_long_cnt, err_zero_cnt}), W'(0));
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("idle_req_ready", W'(s_req_ready), W'(1'b1));
    chk("idle_tready", W'(s_axis_tready), W'(1'b0));
    @(posedge aclk);
    #1;

    // Directed vectors
    for (int v = 0; v < 10; v++) begin
      burst_out = 0;
      run_burst(vecs[v].len, vecs[v].nin, vecs[v].in_keep, 1'b0, 1'b1);
      wait_drain();
      tab_short += vecs[v].d_short;
      tab_long  += vecs[v].d_long;
      chk($sformatf("vec%0d_out_count", v), W'(burst_out), W'(vecs[v].exp_out));
      chk($sformatf("vec%0d_last_keep", v), W'(last_keep_seen), W'(vecs[v].exp_keep));
      chk($sformatf("vec%0d_last_tlast", v), W'(last_tlast_seen), W'(1'b1));
      chk($sformatf("vec%0d_short_cnt", v), W'(err_short_cnt), W'(tab_short));
      chk($sformatf("vec%0d_long_cnt", v), W'(err_long_cnt), W'(tab_long));
    end

    // Zero-length request
    burst_out = 0;
    send_req(0);
    mdl_zero++;
    @(negedge aclk);
    chk("zero_cnt", W'(err_zero_cnt), W'(1));
    chk("zero_req_ready", W'(s_req_ready), W'(1'b1));
    chk("zero_no_output", W'(m_axis_tvalid), W'(1'b0));
    @(posedge aclk);
    #1;

    // Random bursts under random output backpressure
    bp_en = 1'b1;
    total = 0;
    while (total < 1000) begin
      len = $urandom_range(1, 700);
      n   = (len + KB - 1) / KB;
      r   = $urandom_range(0, 3);
      if (r < 2)       nin = n;
      else if (r == 2) nin = $urandom_range(1, n);
      else             nin = n + $urandom_range(1, 3);
      run_burst(len, nin, '0, 1'b1, 1'b0);
      total += nin;
    end
    wait_drain();
    bp_en = 1'b0;
    chk("rand_short_cnt", W'(err_short_cnt), W'(sat(mdl_short)));
    chk("rand_long_cnt", W'(err_long_cnt), W'(sat(mdl_long)));
    chk("rand_zero_cnt", W'(err_zero_cnt), W'(sat(mdl_zero)));

    // Zero counter saturation
    repeat (20) begin
      send_req(0);
      mdl_zero++;
    end
    @(negedge aclk);
    chk("zero_cnt_sat", W'(err_zero_cnt), W'(sat(mdl_zero)));
    @(posedge aclk);
    #1;

    // Reset during beat 2 of a 4-beat burst
    for (int j = 0; j < DATA_BITS / 32; j++) bd[0][j*32 +: 32] = $urandom();
    for (int j = 0; j < DATA_BITS / 32; j++) bd[1][j*32 +: 32] = $urandom();
    exp_q.push_back('{data:bd[0], keep:c_ones, last:1'b0});
    send_req(256);
    send_beat(bd[0], c_ones, 1'b0);
    send_beat(bd[1], c_ones, 1'b0);
    areset = 1'b1;
    @(negedge aclk);
    chk("midrst_req_ready", W'(s_req_ready), W'(1'b0));
    @(posedge aclk);
    #1;
    areset = 1'b0;
    exp_q.delete();
    mdl_short = 0;
    mdl_long  = 0;
    mdl_zero  = 0;
    @(negedge aclk);
    chk("midrst_tvalid", W'(m_axis_tvalid), W'(1'b0));
    chk("midrst_tready", W'(s_axis_tready), W'(1'b0));
    chk("midrst_req_ready", W'(s_req_ready), W'(1'b1));
    chk("midrst_counters", W'({err_short_cnt, err_long_cnt, err_zero_cnt}), W'(0));
    chk("midrst_out_payload", W'({m_axis_tlast, m_axis_tkeep, m_axis_tdata}), W'(0));
    @(posedge aclk);
    #1;
    burst_out = 0;
    run_burst(64, 1, c_ones, 1'b0, 1'b1);
    wait_drain();
    chk("post_rst_out_count", W'(burst_out), W'(1));
    chk("post_rst_last_keep", W'(last_keep_seen), W'(c_ones));
    chk("post_rst_counters", W'({err_short_cnt, err_long_cnt, err_zero_cnt}), W'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
